board_state_link: RTL
=====================

// Module: board_state_link
// PURPOSE
//  Board-side end of the emulator state exchange: the board counterpart of the host's update_state call.
//  Streams the 52-bit outputs_state (LED, HEX0..HEX5) to the host as UART frames on change.
//  Receives 14-bit inputs_state frames (SW[9:0], KEY[3:0]) from the host and drives them to the DUT.
//  Bit layouts match the emulator exactly: SW=[9:0], KEY=[13:10], LED=[9:0], HEXn=[16+7n:10+7n].
// PARAMETERS
//  BAUD_DIV           289  CLK cycles per UART bit (33.3 MHz / 115200); must be >= 4
//  INPUTS_STATE_LEN   14   width of inputs_state; must be <= 16
//  OUTPUTS_STATE_LEN  52   width of outputs_state; must be <= 56
//  RX_TIMEOUT_BITS    16   max idle bit-times between bytes of one RX frame
// PORTS
//  CLK            in   1   system clock
//  RST            in   1   reset; asynchronous, active-high
//  outputs_state  in   52  {HEX5..HEX0, LED} from the DUT
//  send_req       in   1   1-cycle pulse: force a TX frame even if unchanged
//  uart_rx        in   1   serial from host, async, idle high
//  uart_tx        out  1   serial to host, idle high
//  inputs_state   out  14  {KEY, SW} to the DUT
//  tx_busy        out  1   high while a TX frame is on the line
//  rx_valid       out  1   1-cycle pulse: inputs_state just updated
//  rx_err         out  1   1-cycle pulse: RX frame discarded
// BEHAVIOUR
//  UART: 8N1, LSB first. Bit period = BAUD_DIV cycles. No gap between bytes of one frame.
//  Reset values: uart_tx=1, inputs_state=0, tx_busy=0, rx_valid=0, rx_err=0; RX in HUNT; TX in IDLE.
//   Snapshot invalid -> one frame is sent after reset.
//  TX frame: 0xA5, then 7 data bytes = outputs_state zero-extended to 56 bits, byte0 = bits[7:0].
//  TX FSM: IDLE -> START -> DATA(8) -> STOP, repeated per byte -> IDLE.
//   Trigger in IDLE: snapshot invalid, OR outputs_state != last snapshot, OR send_req pending.
//   On trigger: latch snapshot and mark it valid; tx_busy=1 and start bit driven on the next cycle.
//   tx_busy falls the cycle after the final stop bit's BAUD_DIV cycles end.
//  TX boundaries:
//   - outputs_state changing mid-frame does not alter the frame in flight.
//   - Compare happens again in IDLE, so a change mid-frame yields exactly one follow-up frame.
//   - send_req during a frame is latched (one deep) and served next.
//   - send_req together with a change in IDLE produces one frame only.
//  RX input: uart_rx goes through a 2-flop synchronizer.
//   Start bit is validated at mid-bit (BAUD_DIV/2); if the line is high there, it is a glitch and ignored.
//   Data bits and the stop bit are sampled at mid-bit.
//  RX FSM: HUNT -> D0 -> D1 -> (CHK) -> HUNT.
//   HUNT waits for byte 0x5A; other bytes are dropped silently.
//   D0 = inputs_state[7:0]; D1[INPUTS_STATE_LEN-9:0] = upper bits; remaining D1 bits ignored.
//  Commit: the cycle after the last byte's stop sample, inputs_state <= {D1, D0} and rx_valid=1.
//   inputs_state holds between frames.
//  RX errors: rx_err pulses and the FSM returns to HUNT, with inputs_state unchanged, when:
//   - any stop bit samples 0 (framing error), or
//   - idle exceeds RX_TIMEOUT_BITS*BAUD_DIV cycles between bytes outside HUNT.
//  RX and TX are fully independent and may run simultaneously.
//  RST mid-frame: uart_tx goes to 1 immediately, partial frames are discarded, and all state is reset.
// CONFIGURATION
//  `STATE_LINK_CHECKSUM_EN defined:
//   - TX appends a 9th byte = XOR of the 7 data bytes.
//   - RX expects a 4th byte = D0^D1 (CHK state). On mismatch: rx_err, no commit, back to HUNT.
//  Undefined: TX frame is 8 bytes; RX frame is 3 bytes; no CHK state.
// TESTING (BAUD_DIV=4, checksum off unless stated)
//  1. Reset release, outputs_state=0 -> frame A5 00 00 00 00 00 00 00.
//     Frame lasts 80*4=320 cycles; tx_busy high for exactly those cycles.
//  2. outputs_state=52'h1 then 52'h3FF mid-frame -> frame 1 carries byte0=01.
//     Exactly one follow-up frame with byte0=FF, byte1=03. No third frame.
//  3. RX bytes 5A 3F 2A -> inputs_state=14'h2A3F and rx_valid pulses once, the cycle after the 3rd stop sample.
//  4. RX 5A 11 with stop bit=0 -> rx_err pulse, inputs_state unchanged.
//     A following 5A 01 00 commits 14'h0001.
//  5. RX 5A 12, then idle 17 bit-times -> rx_err pulse.
//     Next 12 34 is ignored; inputs_state unchanged.
//  6. Checksum on: TX 52'h0102 -> A5 02 01 00 00 00 00 00 03.
//     RX 5A 01 02 04 -> rx_err, no commit; RX 5A 01 02 03 -> commits 14'h0201.

Source files
------------

// File: rtl/board_state_link.sv
// Board end of the emulator state link: streams outputs_state to the host over UART and
// applies inputs_state frames received from it. Define STATE_LINK_CHECKSUM_EN for XOR-checked frames.
module board_state_link #(
  parameter int BAUD_DIV          = 289,
  parameter int INPUTS_STATE_LEN  = 14,
  parameter int OUTPUTS_STATE_LEN = 52,
  parameter int RX_TIMEOUT_BITS   = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [OUTPUTS_STATE_LEN-1:0] outputs_state,
  input  logic                         send_req,
  input  logic                         uart_rx,
  output logic                         uart_tx,
  output logic [INPUTS_STATE_LEN-1:0]  inputs_state,
  output logic                         tx_busy,
  output logic                         rx_valid,
  output logic                         rx_err
);

  localparam int CNT_W      = $clog2(BAUD_DIV);
  localparam int RX_TIMEOUT = RX_TIMEOUT_BITS * BAUD_DIV;
  localparam int TO_W       = $clog2(RX_TIMEOUT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  // Start bit is checked two cycles early to absorb the synchronizer and edge-detect latency.
  localparam logic [CNT_W-1:0] START_MID = CNT_W'(BAUD_DIV / 2 - 2);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RX_TIMEOUT - 1);

`ifdef STATE_LINK_CHECKSUM_EN
  localparam logic [3:0] TX_LAST = 4'd8;
`else
  localparam logic [3:0] TX_LAST = 4'd7;
`endif

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e                    tx_state_q;
  logic [OUTPUTS_STATE_LEN-1:0] snap_q;
  logic                         snap_valid_q;
  logic                         req_pend_q;
  logic                         tx_q;
  logic                         tx_busy_q;
  logic [CNT_W-1:0]             tx_cnt_q;
  logic [2:0]                   tx_bit_q;
  logic [3:0]                   tx_byte_q;
  logic [7:0]                   tx_shift_q;
  logic [55:0]                  snap_ext;
  logic [7:0]                   tx_bytes [16];
`ifdef STATE_LINK_CHECKSUM_EN
  logic [7:0]                   tx_chk;
`endif

  assign snap_ext = 56'(snap_q);

  always_comb begin
    // NOTE: every entry gets a default first so no path can leave a latch behind.
    for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;
    tx_bytes[0] = 8'hA5;
    for (int i = 0; i < 7; i++) tx_bytes[i + 1] = snap_ext[8*i +: 8];
`ifdef STATE_LINK_CHECKSUM_EN
    tx_chk = 8'h00;
    for (int i = 0; i < 7; i++) tx_chk = tx_chk ^ snap_ext[8*i +: 8];
    tx_bytes[8] = tx_chk;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q   <= TX_IDLE;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      req_pend_q   <= 1'b0;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_byte_q    <= '0;
      tx_shift_q   <= '0;
    end else begin
      if (send_req && tx_state_q != TX_IDLE) req_pend_q <= 1'b1;
      case (tx_state_q)
        TX_IDLE: begin
          if (!snap_valid_q || outputs_state != snap_q || req_pend_q || send_req) begin
            snap_q       <= outputs_state;
            snap_valid_q <= 1'b1;
            req_pend_q   <= 1'b0;
            tx_shift_q   <= 8'hA5;
            tx_byte_q    <= '0;
            tx_cnt_q     <= '0;
            tx_q         <= 1'b0;
            tx_busy_q    <= 1'b1;
            tx_state_q   <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_byte_q == TX_LAST) begin
              tx_busy_q  <= 1'b0;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_byte_q  <= tx_byte_q + 4'd1;
              tx_shift_q <= tx_bytes[tx_byte_q + 4'd1];
              tx_q       <= 1'b0;
              tx_state_q <= TX_START;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX byte receiver
  typedef enum logic [1:0] {RB_IDLE, RB_START, RB_DATA, RB_STOP} rb_state_e;
  typedef enum logic [1:0] {RF_HUNT, RF_D0, RF_D1, RF_CHK} rf_state_e;

  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_prev_q;
  rb_state_e        rb_state_q;
  logic [CNT_W-1:0] rb_cnt_q;
  logic [2:0]       rb_bit_q;
  logic [7:0]       rb_shift_q;
  logic             byte_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Falling-edge start detection keeps a held-low line after a framing error from re-triggering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rb_state_q <= RB_IDLE;
      rb_cnt_q   <= '0;
      rb_bit_q   <= '0;
      rb_shift_q <= '0;
    end else begin
      case (rb_state_q)
        RB_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rb_cnt_q   <= '0;
            rb_state_q <= RB_START;
          end
        end
        RB_START: begin
          if (rb_cnt_q == START_MID) begin
            rb_cnt_q   <= '0;
            rb_bit_q   <= '0;
            rb_state_q <= rx_sync_q ? RB_IDLE : RB_DATA;
          end else begin
            rb_cnt_q <= rb_cnt_q + 1'b1;
          end
        end
        RB_DATA: begin
          if (rb_cnt_q == BIT_LAST) begin
            rb_cnt_q   <= '0;
            rb_shift_q <= {rx_sync_q, rb_shift_q[7:1]};
            rb_bit_q   <= rb_bit_q + 1'b1;
            if (rb_bit_q == 3'd7) rb_state_q <= RB_STOP;
          end else begin
            rb_cnt_q <= rb_cnt_q + 1'b1;
          end
        end
        RB_STOP: begin
          if (rb_cnt_q == BIT_LAST) begin
            rb_cnt_q   <= '0;
            rb_state_q <= RB_IDLE;
          end else begin
            rb_cnt_q <= rb_cnt_q + 1'b1;
          end
        end
        default: rb_state_q <= RB_IDLE;
      endcase
    end
  end

  assign byte_done = (rb_state_q == RB_STOP) && (rb_cnt_q == BIT_LAST);

  // ---------------------------------------------------------------- RX frame FSM
  rf_state_e                   rf_state_q;
  logic [7:0]                  d0_q;
`ifdef STATE_LINK_CHECKSUM_EN
  logic [7:0]                  d1_q;
`endif
  logic [TO_W-1:0]             to_cnt_q;
  logic [INPUTS_STATE_LEN-1:0] inputs_state_q;
  logic                        rx_valid_q;
  logic                        rx_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_state_q     <= RF_HUNT;
      d0_q           <= '0;
`ifdef STATE_LINK_CHECKSUM_EN
      d1_q           <= '0;
`endif
      to_cnt_q       <= '0;
      inputs_state_q <= '0;
      rx_valid_q     <= 1'b0;
      rx_err_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (byte_done) begin
        to_cnt_q <= '0;
        if (!rx_sync_q) begin
          rx_err_q   <= 1'b1;
          rf_state_q <= RF_HUNT;
        end else begin
          case (rf_state_q)
            RF_HUNT: if (rb_shift_q == 8'h5A) rf_state_q <= RF_D0;
            RF_D0: begin
              d0_q       <= rb_shift_q;
              rf_state_q <= RF_D1;
            end
`ifdef STATE_LINK_CHECKSUM_EN
            RF_D1: begin
              d1_q       <= rb_shift_q;
              rf_state_q <= RF_CHK;
            end
            RF_CHK: begin
              if (rb_shift_q == (d0_q ^ d1_q)) begin
                inputs_state_q <= INPUTS_STATE_LEN'({d1_q, d0_q});
                rx_valid_q     <= 1'b1;
              end else begin
                rx_err_q <= 1'b1;
              end
              rf_state_q <= RF_HUNT;
            end
`else
            RF_D1: begin
              inputs_state_q <= INPUTS_STATE_LEN'({rb_shift_q, d0_q});
              rx_valid_q     <= 1'b1;
              rf_state_q     <= RF_HUNT;
            end
`endif
            default: rf_state_q <= RF_HUNT;
          endcase
        end
      end else if (rf_state_q != RF_HUNT && rb_state_q == RB_IDLE) begin
        if (to_cnt_q == TO_LAST) begin
          to_cnt_q   <= '0;
          rx_err_q   <= 1'b1;
          rf_state_q <= RF_HUNT;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign uart_tx      = tx_q;
  assign tx_busy      = tx_busy_q;
  assign inputs_state = inputs_state_q;
  assign rx_valid     = rx_valid_q;
  assign rx_err       = rx_err_q;

endmodule
